// File: rtl/data_mem_responder_if.sv
// Request/response bus between a data-memory initiator and the responder.
// The initiator drives requests and consumes responses. The responder
// accepts requests and produces responses.
interface data_mem_responder_if #(
  parameter int DATA_W     = 32,
  parameter int DM_ADDRESS = 9
) ();

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [DM_ADDRESS-1:0] req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [3:0]            req_wstrb;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_W-1:0]     resp_rdata;
  logic                  resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_wstrb, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_wstrb, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/data_mem_responder.sv
// Single-outstanding data memory responder with a fixed access latency.
// The responder accepts one request in IDLE and waits LATENCY-1 counted
// cycles in ACCESS. It then performs the load or store and holds the
// response in RESP until the initiator consumes it.
module data_mem_responder #(
  parameter int DATA_W     = 32,
  parameter int DM_ADDRESS = 9,
  parameter int LATENCY    = 2
) (
  input logic                  clk,
  input logic                  reset,
  data_mem_responder_if.slave  bus
);

  localparam int         WORDS    = 2 ** (DM_ADDRESS - 2);
  localparam int         IDX_W    = DM_ADDRESS - 2;
  localparam int         LANES    = (DATA_W / 8 < 4) ? DATA_W / 8 : 4;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                state, state_next;
  logic [3:0]            cnt;
  logic                  write_q;
  logic [DM_ADDRESS-1:0] addr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [3:0]            wstrb_q;
  logic [DATA_W-1:0]     rdata_q;
  logic                  err_q;
  logic [DATA_W-1:0]     mem [WORDS];

  logic                  accept;
  logic                  do_access;
  logic                  misaligned;
  logic [IDX_W-1:0]      idx;

  assign accept     = (state == IDLE) && bus.req_valid;
  assign do_access  = (state == ACCESS) && (cnt == 4'd0);
  assign idx        = addr_q[DM_ADDRESS-1:2];
  assign misaligned = (addr_q[1:0] != 2'b00);

  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = (state == RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

  // State register.
  // NOTE: sequential blocks use non-blocking (<=) so all flops update together at the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state decode.
  // NOTE: default assigned first so no path leaves state_next unassigned (no latch).
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (bus.req_valid)    state_next = ACCESS;
      ACCESS:  if (cnt == 4'd0)      state_next = RESP;
      RESP:    if (bus.resp_ready)   state_next = IDLE;
      default:                       state_next = IDLE;
    endcase
  end

  // Latch the request on acceptance and count down the access latency.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= 4'd0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= 4'd0;
    end else if (accept) begin
      cnt     <= CNT_INIT;
      write_q <= bus.req_write;
      addr_q  <= bus.req_addr;
      wdata_q <= bus.req_wdata;
      wstrb_q <= bus.req_wstrb;
    end else if ((state == ACCESS) && (cnt != 4'd0)) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Response registers: loaded at the access edge and cleared when consumed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (do_access) begin
      err_q   <= misaligned;
      rdata_q <= (write_q || misaligned) ? '0 : mem[idx];
    end else if ((state == RESP) && bus.resp_ready) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end
  end

  // Storage array with per-byte write lanes; misaligned stores are dropped.
  // NOTE: the array must read as all-zero after reset, so every word is a reset flop rather than RAM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int w = 0; w < WORDS; w++) mem[w] <= '0;
    end else if (do_access && write_q && !misaligned) begin
      for (int i = 0; i < LANES; i++) begin
        if (wstrb_q[i]) mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

endmodule
